// File: rtl/h2_console_pkg.sv
// h2_console_pkg: shared types and constants for the h2 console I/O blocks.
//   byte_t             - 8-bit console byte
//   CONSOLE_EMPTY_CODE - default byte returned when the core reads an empty input FIFO
//   CONSOLE_*_ADDR     - h2 I/O decode addresses shared by the console input and output sides
package h2_console_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CONSOLE_EMPTY_CODE = 8'hFF;

  localparam logic [15:0] CONSOLE_OUT_ADDR    = 16'h4002;  // write: byte + cstrobe
  localparam logic [15:0] CONSOLE_IN_ADDR     = 16'h4004;  // read: pops one byte
  localparam logic [15:0] CONSOLE_STATUS_ADDR = 16'h4006;  // read: avail/underrun/level

endpackage

// File: rtl/h2_byte_fifo.sv
// h2_byte_fifo: byte FIFO with an AW+1 bit occupancy count.
//   clk, rst            - clock, async active-high reset (empties the FIFO)
//   wr_en_i, wr_data_i  - push request; ignored while full
//   rd_en_i             - pop request; ignored while empty
//   rd_data_o           - head byte (combinational view of the array)
//   count_o             - registered occupancy 0..DEPTH
//   full_o, empty_o     - derived from the registered count only
import h2_console_pkg::*;

module h2_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  byte_t       wr_data_i,
  input  logic        rd_en_i,
  output byte_t       rd_data_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);  // wraps modulo DEPTH
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/h2_console_in.sv
// h2_console_in: console input channel for the h2 core.
//   phi, rst                       - clock, async active-high reset
//   host_data/host_valid/host_ready- host push side (ready = !full, from registered count)
//   cpu_rd                         - one-cycle read strobe from the core
//   cpu_data, cpu_rdvalid          - registered read byte and its one-cycle valid pulse
//   cpu_avail                      - FIFO non-empty
//   cpu_underrun, cpu_clr          - sticky empty-read flag and its clear
//   level                          - occupancy 0..DEPTH
import h2_console_pkg::*;

module h2_console_in #(
  parameter  int    DEPTH      = 16,
  parameter  byte_t EMPTY_CODE = CONSOLE_EMPTY_CODE,
  localparam int    AW         = $clog2(DEPTH)
) (
  input  logic        phi,
  input  logic        rst,
  input  byte_t       host_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        cpu_rd,
  output byte_t       cpu_data,
  output logic        cpu_rdvalid,
  output logic        cpu_avail,
  output logic        cpu_underrun,
  input  logic        cpu_clr,
  output logic [AW:0] level
);

  byte_t head;
  logic  full, empty;
  byte_t cpu_data_q, cpu_data_d;
  logic  rdvalid_q, rdvalid_d;
  logic  underrun_q, underrun_d;

  // The FIFO gates rd with its own empty flag, so a push into an empty
  // FIFO during a read is stored rather than bypassed to the reader.
  h2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (phi),
    .rst       (rst),
    .wr_en_i   (host_valid),
    .wr_data_i (host_data),
    .rd_en_i   (cpu_rd),
    .rd_data_o (head),
    .count_o   (level),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    cpu_data_d = cpu_data_q;
    rdvalid_d  = cpu_rd;
    underrun_d = underrun_q;
    if (cpu_rd) cpu_data_d = empty ? EMPTY_CODE : head;
    if (cpu_clr) underrun_d = 1'b0;
    // Ordered after the clear so a same-cycle empty read keeps the flag set.
    if (cpu_rd && empty) underrun_d = 1'b1;
  end

  always_ff @(posedge phi or posedge rst) begin
    if (rst) begin
      cpu_data_q <= 8'h00;
      rdvalid_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cpu_data_q <= cpu_data_d;
      rdvalid_q  <= rdvalid_d;
      underrun_q <= underrun_d;
    end
  end

  assign host_ready   = ~full;
  assign cpu_avail    = ~empty;
  assign cpu_data     = cpu_data_q;
  assign cpu_rdvalid  = rdvalid_q;
  assign cpu_underrun = underrun_q;

endmodule

// File: tb/tb_h2_console_in.sv
// tb_h2_console_in: directed bench for h2_console_in. Stimulus pushes the
// expected read byte into a scoreboard queue for every cpu_rd; a monitor
// pops and compares whenever cpu_rdvalid is seen.
import h2_console_pkg::*;

module tb_h2_console_in;

  localparam int DEPTH = 16;

  logic       phi, rst;
  byte_t      host_data;
  logic       host_valid, host_ready;
  logic       cpu_rd, cpu_rdvalid, cpu_avail, cpu_underrun, cpu_clr;
  byte_t      cpu_data;
  logic [4:0] level;

  int total, bad;
  byte_t sb[$];  // expected read bytes, in order
  byte_t mq[$];  // bytes the bench believes are stored

  h2_console_in #(.DEPTH(DEPTH), .EMPTY_CODE(8'hFF)) dut (
    .phi          (phi),
    .rst          (rst),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .cpu_rd       (cpu_rd),
    .cpu_data     (cpu_data),
    .cpu_rdvalid  (cpu_rdvalid),
    .cpu_avail    (cpu_avail),
    .cpu_underrun (cpu_underrun),
    .cpu_clr      (cpu_clr),
    .level        (level)
  );

  initial phi = 1'b0;
  always #5 phi = ~phi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: consume one scoreboard entry per read-valid pulse.
  always @(negedge phi) begin
    if (cpu_rdvalid === 1'b1) begin
      if (sb.size() == 0) chk("rdvalid_unexpected", {31'd0, cpu_rdvalid}, 32'd0);
      else chk("rd_data", {24'd0, cpu_data}, {24'd0, sb.pop_front()});
    end
  end

  // One clock of stimulus; returns #1 after the rising edge.
  task automatic cycle(input logic v, input byte_t d, input logic rd, input logic clr);
    bit acc;
    host_valid = v; host_data = d; cpu_rd = rd; cpu_clr = clr;
    acc = v && (mq.size() < DEPTH);
    if (rd) begin
      if (mq.size() > 0) sb.push_back(mq.pop_front());
      else sb.push_back(8'hFF);
    end
    if (acc) mq.push_back(d);
    @(posedge phi); #1;
    host_valid = 1'b0; cpu_rd = 1'b0; cpu_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; host_valid = 1'b0; host_data = 8'h00; cpu_rd = 1'b0; cpu_clr = 1'b0;
    @(negedge phi); @(negedge phi);
    chk("rst_level", level, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_avail", cpu_avail, 0);
    chk("rst_data", cpu_data, 8'h00);
    chk("rst_rdvalid", cpu_rdvalid, 0);
    chk("rst_underrun", cpu_underrun, 0);
    rst = 1'b0;

    // Three bytes in, three back-to-back reads out.
    cycle(1, 8'h41, 0, 0); cycle(1, 8'h42, 0, 0); cycle(1, 8'h43, 0, 0);
    chk("abc_level3", level, 3);
    chk("abc_avail", cpu_avail, 1);
    cycle(0, 8'h00, 1, 0);
    chk("abc_rdvalid1", cpu_rdvalid, 1);
    chk("abc_level2", level, 2);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    chk("abc_level0", level, 0);
    chk("abc_avail_drop", cpu_avail, 0);
    idle(1);
    chk("abc_rdvalid_low", cpu_rdvalid, 0);
    chk("abc_data_hold", cpu_data, 8'h43);

    // Fill to DEPTH, then a refused push, then push+pop at full.
    for (int i = 0; i < DEPTH; i++) cycle(1, byte_t'(i), 0, 0);
    chk("full_level", level, 16);
    chk("full_ready", host_ready, 0);
    cycle(1, 8'h10, 0, 0);
    chk("full_refused", level, 16);
    cycle(1, 8'h10, 1, 0);
    chk("full_pushpop_level", level, 15);
    chk("full_pushpop_ready", host_ready, 1);
    for (int i = 0; i < 15; i++) cycle(0, 8'h00, 1, 0);  // expect 01..0F, no 10
    chk("full_drained", level, 0);

    // Empty read, clear, clear racing an empty read.
    cycle(0, 8'h00, 1, 0);
    chk("ur_set", cpu_underrun, 1);
    chk("ur_data", cpu_data, 8'hFF);
    chk("ur_level", level, 0);
    cycle(0, 8'h00, 0, 1);
    chk("ur_clr", cpu_underrun, 0);
    cycle(0, 8'h00, 1, 1);
    chk("ur_clr_race", cpu_underrun, 1);
    cycle(0, 8'h00, 0, 1);
    chk("ur_clr2", cpu_underrun, 0);
    // Push into empty with a read in the same cycle: stored, read sees FF.
    cycle(1, 8'h55, 1, 0);
    chk("nobypass_data", cpu_data, 8'hFF);
    chk("nobypass_level", level, 1);
    cycle(0, 8'h00, 1, 1);
    chk("nobypass_pop", cpu_data, 8'h55);
    chk("nobypass_ur_cleared", cpu_underrun, 0);

    // Streaming at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1, byte_t'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, byte_t'(8'h85 + i), 1, 0);
      chk("wrap_level", level, 5);
    end
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);
    chk("wrap_drained", level, 0);
    idle(1);

    // Reset with 7 stored bytes discards them.
    for (int i = 0; i < 7; i++) cycle(1, byte_t'(8'hA0 + i), 0, 0);
    chk("pre_rst_level", level, 7);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ready", host_ready, 1);
    chk("mid_rst_avail", cpu_avail, 0);
    chk("mid_rst_data", cpu_data, 8'h00);
    mq.delete();
    @(negedge phi);
    rst = 1'b0;
    cycle(0, 8'h00, 1, 0);
    chk("post_rst_data", cpu_data, 8'hFF);
    chk("post_rst_underrun", cpu_underrun, 1);
    idle(2);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
